aes_dec_round_ctrl: RTL
=======================

Name: aes_dec_round_ctrl

Overview:
Iterative AES decryption round sequencer. Owns the 128-bit cipher state register and steps it through one initial AddRoundKey, NR-1 full inverse rounds and one final inverse round. Each inverse round is InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns, which the final round skips. The round datapath is external and combinational. Round keys come from an external key store indexed by this block. The block sits between the host-side block stream (valid/ready) and the decryption datapath.

Parameters:
NR, 10, number of rounds (10/12/14 for AES-128/192/256)
KW, 4, width of key_idx; must satisfy 2**KW > NR

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  ciphertext block offered
in_ready  output  1  block can be accepted
in_block  input  128  ciphertext
out_valid  output  1  plaintext available
out_ready  input  1  consumer takes plaintext
out_block  output  128  plaintext (equals the state register)
key_idx  output  KW  round-key index requested from the key store
key_valid  input  1  round key for key_idx is present this cycle
dp_state  output  128  current state driven into the datapath
dp_first  output  1  datapath does AddRoundKey only (initial step)
dp_skip_mix  output  1  datapath omits InvMixColumns (final round)
dp_result  input  128  combinational datapath output for dp_state/key_idx
busy  output  1  a block is in flight (state not IDLE)

Behaviour:
- States: IDLE, INIT, ROUND, FINAL, DONE. A round counter rnd (KW bits) drives key_idx directly (key_idx = rnd).
- Reset (async, any state, including mid-block): state=IDLE, rnd=NR, state register=0, out_valid=0, in_ready=1, busy=0, dp_first=0, dp_skip_mix=0. An in-flight block is dropped and no partial output is produced.
- IDLE: in_ready=1. On in_valid&&in_ready the state register loads in_block, rnd=NR, and the FSM goes to INIT.
- INIT: dp_first=1. When key_valid=1: state register <= dp_result, rnd <= NR-1, then go to ROUND. When key_valid=0: hold everything (stall).
- ROUND: full inverse round. When key_valid=1: state register <= dp_result, rnd <= rnd-1; if rnd==1 go to FINAL. When key_valid=0: stall.
- FINAL: dp_skip_mix=1, rnd==0. When key_valid=1: state register <= dp_result and go to DONE.
- DONE: out_valid=1, out_block stable. On out_ready go to IDLE with rnd=NR. in_ready=0 throughout DONE, so there is no same-cycle accept.
- in_ready=1 only in IDLE. in_block is ignored outside IDLE.
- Latency with key_valid held high: out_valid rises after the (NR+1)th rising edge following the accepting edge (11 edges for NR=10). Each key_valid=0 cycle adds exactly one cycle.
- Throughput: one block per NR+3 cycles minimum (accept, NR+1 processing, one DONE cycle).
- dp_first and dp_skip_mix are decoded from the FSM state, never both 1. Both are 0 in IDLE and DONE.
- rnd never underflows; its sequence is NR, NR-1, …, 0.

Optional Feature:
AES_DEC_ABORT_EN
- Defined: adds input port abort (1 bit). If abort=1 on a clock edge in INIT, ROUND, FINAL or DONE, the next state is IDLE, rnd=NR, out_valid=0, and the state register is cleared to 0. abort has priority over key_valid and out_ready. abort in IDLE has no effect and does not block an accept.
- Undefined: no abort port; a block can only be cancelled by rst.

Decomposition:
- Package aes_dec_pkg: FSM state enum, the AES-128/192/256 NR constants, and the 128-bit block typedef.
- No sub-module. FSM, round counter and state register form one module. The datapath instance sits in the parent.

Test Plan:
- FIPS-197 AES-128 vector (key 000102…0f), bench datapath + key store, key_valid=1: in_block 69c4e0d86a7b0430d8cdb78070b4c55a -> out_block 00112233445566778899aabbccddeeff, out_valid after exactly 11 edges; key_idx sequence 10,9,…,0.
- Same vector with key_valid low for 3 random cycles -> same plaintext, out_valid at 14 edges; state register and key_idx hold during each stall.
- out_ready held low 5 cycles in DONE -> out_valid and out_block stable, in_ready=0; a second block is accepted only after the out_ready cycle, and back-to-back blocks take 13 cycles each.
- rst asserted asynchronously mid-ROUND (key_idx=5) -> outputs immediately at reset values; the next block decrypts correctly.
- dp_first=1 only when key_idx=10; dp_skip_mix=1 only when key_idx=0; never both.
- With AES_DEC_ABORT_EN: abort in ROUND -> IDLE next edge with out_valid=0 and in_ready=1; abort in IDLE together with in_valid -> block accepted.

Source files
------------

// File: rtl/aes_dec_pkg.sv
// rtl/aes_dec_pkg.sv - shared types and constants for the AES decryption round sequencer
//
// Contents:
//   dec_state_e  - sequencer FSM states
//   NR_AES128/192/256 - round counts per key size
//   aes_block_t  - 128-bit cipher block / state register type
//   nr_for_key_bits() - round count for a given key length

package aes_dec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } dec_state_e;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    typedef logic [127:0] aes_block_t;

    // Unknown key lengths fall back to the AES-128 round count.
    function automatic int nr_for_key_bits(input int key_bits);
        case (key_bits)
            192:     return NR_AES192;
            256:     return NR_AES256;
            default: return NR_AES128;
        endcase
    endfunction

endpackage

// File: rtl/aes_dec_round_ctrl.sv
// rtl/aes_dec_round_ctrl.sv - iterative AES decryption round sequencer
//
// Owns the 128-bit cipher state register and walks it through the initial
// AddRoundKey, NR-1 full inverse rounds and the final inverse round. The round
// datapath and round-key store are external; this block only sequences them.
//
// Build option: AES_DEC_ABORT_EN adds the abort input (cancel an in-flight block).
//
// Parameters:
//   NR  rounds (10/12/14), must be >= 2
//   KW  width of key_idx, 2**KW > NR
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready/in_block     ciphertext handshake (accept only in IDLE)
//   out_valid/out_ready/out_block  plaintext handshake (out_block = state register)
//   key_idx       round-key index requested from the key store (= round counter)
//   key_valid     round key for key_idx is present; low stalls the sequencer
//   dp_state      state register driven into the datapath
//   dp_first      datapath performs AddRoundKey only
//   dp_skip_mix   datapath omits InvMixColumns
//   dp_result     combinational datapath result
//   busy          a block is in flight
//   abort         (AES_DEC_ABORT_EN only) drop the in-flight block

module aes_dec_round_ctrl
    import aes_dec_pkg::*;
#(
    parameter int NR = NR_AES128,
    parameter int KW = 4
) (
    input  logic          clk,
    input  logic          rst,
`ifdef AES_DEC_ABORT_EN
    input  logic          abort,
`endif
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_block,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_block,
    output logic [KW-1:0] key_idx,
    input  logic          key_valid,
    output logic [127:0]  dp_state,
    output logic          dp_first,
    output logic          dp_skip_mix,
    input  logic [127:0]  dp_result,
    output logic          busy
);

    localparam logic [KW-1:0] RND_START = KW'(NR);
    localparam logic [KW-1:0] RND_AFTER_INIT = KW'(NR - 1);
    localparam logic [KW-1:0] RND_LAST_FULL = KW'(1);

    dec_state_e state;
    logic [KW-1:0] rnd;
    aes_block_t blk;

    assign key_idx   = rnd;
    assign dp_state  = blk;
    assign out_block = blk;

    // All handshake and datapath-mode outputs are registered and updated
    // together with the state so they always match the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            rnd         <= RND_START;
            blk         <= '0;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            dp_first    <= 1'b0;
            dp_skip_mix <= 1'b0;
        end else begin
`ifdef AES_DEC_ABORT_EN
            // Abort wins over key_valid and out_ready; ignored while idle so
            // it cannot block an accept.
            if (abort && state != ST_IDLE) begin
                state       <= ST_IDLE;
                rnd         <= RND_START;
                blk         <= '0;
                out_valid   <= 1'b0;
                in_ready    <= 1'b1;
                busy        <= 1'b0;
                dp_first    <= 1'b0;
                dp_skip_mix <= 1'b0;
            end else begin
`endif
            case (state)
                ST_IDLE: begin
                    // in_ready is 1 exactly in IDLE, so in_valid alone accepts.
                    if (in_valid) begin
                        blk       <= in_block;
                        rnd       <= RND_START;
                        state     <= ST_INIT;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        dp_first  <= 1'b1;
                    end
                end
                ST_INIT: begin
                    if (key_valid) begin
                        blk      <= dp_result;
                        rnd      <= RND_AFTER_INIT;
                        state    <= ST_ROUND;
                        dp_first <= 1'b0;
                    end
                end
                ST_ROUND: begin
                    if (key_valid) begin
                        blk <= dp_result;
                        rnd <= rnd - KW'(1);
                        // Round 1 is the last full round; key 0 goes to FINAL.
                        if (rnd == RND_LAST_FULL) begin
                            state       <= ST_FINAL;
                            dp_skip_mix <= 1'b1;
                        end
                    end
                end
                ST_FINAL: begin
                    if (key_valid) begin
                        blk         <= dp_result;
                        state       <= ST_DONE;
                        dp_skip_mix <= 1'b0;
                        out_valid   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // in_ready stays low here: no same-cycle re-accept.
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        rnd       <= RND_START;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    rnd         <= RND_START;
                    out_valid   <= 1'b0;
                    in_ready    <= 1'b1;
                    busy        <= 1'b0;
                    dp_first    <= 1'b0;
                    dp_skip_mix <= 1'b0;
                end
            endcase
`ifdef AES_DEC_ABORT_EN
            end
`endif
        end
    end

endmodule
